// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: datapath width, PC increment and fetch FSM states.
package pc_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      WAIT  = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_if_slot.sv
// One-entry output buffer between fetch and decode: filled by a memory response,
// drained by a decode handshake, flushed by a redirect.
module if_slot
   import pc_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_fill,
   input  logic [XLEN-1:0] i_fill_instr,
   input  logic [XLEN-1:0] i_fill_pc,
   input  logic            i_flush,
   input  logic            i_ready,
   output logic            o_full,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc
);

   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;
   logic            w_drain;

   // A redirect hides the slot from decode so no wrong-path instruction is consumed.
   assign o_valid = r_valid && !i_flush;
   assign w_drain = o_valid && i_ready;
   assign o_full  = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

   // NOTE: state uses non-blocking assignments; the data registers are reset too so
   // if_instr/if_pc read as zero after reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else begin
         if (i_flush)
            r_valid <= 1'b0;
         else if (i_fill)
            r_valid <= 1'b1;
         else if (w_drain)
            r_valid <= 1'b0;

         if (i_fill) begin
            r_instr <= i_fill_instr;
            r_pc    <= i_fill_pc;
         end
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// RV32I instruction-fetch stage: owns the PC, issues one outstanding word fetch at a
// time and buffers each returned instruction for decode; redirects flush wrong-path work.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            misalign_err
);

   fetch_state_e    r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt;
   logic            r_discard, w_discard_nxt;
   logic            r_misalign;
   logic            w_req_valid;
   logic            w_fill;
   logic            w_slot_full;

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_discard_nxt = r_discard;
      w_fill        = 1'b0;
      w_req_valid   = 1'b0;

      if (r_state == FETCH) begin
         w_req_valid = !w_slot_full || if_ready;
         if (w_req_valid && imem_req_ready) begin
            w_state_nxt   = WAIT;
            // A request accepted alongside a redirect fetches the old path; drop its data.
            w_discard_nxt = redirect_valid;
         end
      end else begin
         if (imem_rsp_valid) begin
            w_state_nxt   = FETCH;
            w_discard_nxt = 1'b0;
            if (!r_discard && !redirect_valid) begin
               w_fill   = 1'b1;
               w_pc_nxt = r_pc + PC_STEP;
            end
         end else if (redirect_valid) begin
            w_discard_nxt = 1'b1;
         end
      end

      if (redirect_valid)
         w_pc_nxt = align_word(redirect_pc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FETCH;
         r_pc       <= RESET_PC;
         r_discard  <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_discard  <= w_discard_nxt;
         r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_pc;
   assign misalign_err   = r_misalign;

   if_slot u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_fill       (w_fill),
      .i_fill_instr (imem_rdata),
      .i_fill_pc    (r_pc),
      .i_flush      (redirect_valid),
      .i_ready      (if_ready),
      .o_full       (w_slot_full),
      .o_valid      (if_valid),
      .o_instr      (if_instr),
      .o_pc         (if_pc)
   );

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: variable-latency memory model, backpressure, redirects,
// misalignment, PC wrap and mid-operation reset.
module tb_pc_fetch;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        misalign_err;

   logic        wr_req_valid;
   logic [31:0] wr_addr;
   logic        wr_rsp_valid;
   logic [31:0] wr_rdata;
   logic        wr_if_valid;
   logic [31:0] wr_if_instr;
   logic [31:0] wr_if_pc;
   logic        wr_misalign;

   int          mem_k;
   logic        m_pend;
   int          m_cnt;
   logic [31:0] m_addr;

   int          total = 0;
   int          bad   = 0;

   pc_fetch u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .misalign_err   (misalign_err)
   );

   pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .imem_req_valid (wr_req_valid),
      .imem_req_ready (1'b1),
      .imem_addr      (wr_addr),
      .imem_rsp_valid (wr_rsp_valid),
      .imem_rdata     (wr_rdata),
      .if_valid       (wr_if_valid),
      .if_ready       (1'b1),
      .if_instr       (wr_if_instr),
      .if_pc          (wr_if_pc),
      .misalign_err   (wr_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      return a ^ 32'hA5A5_0013;
   endfunction

   // Memory for the main instance: response k cycles after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend         <= 1'b0;
         m_cnt          <= 0;
         m_addr         <= '0;
         imem_rsp_valid <= 1'b0;
         imem_rdata     <= '0;
      end else begin
         imem_rsp_valid <= 1'b0;
         if (m_pend) begin
            if (m_cnt == 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rdata     <= exp_instr(m_addr);
               m_pend         <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            if (mem_k == 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rdata     <= exp_instr(imem_addr);
            end else begin
               m_pend <= 1'b1;
               m_cnt  <= mem_k - 1;
               m_addr <= imem_addr;
            end
         end
      end
   end

   // Memory for the wrap instance: always ready, k = 1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_rsp_valid <= 1'b0;
         wr_rdata     <= '0;
      end else begin
         wr_rsp_valid <= wr_req_valid;
         wr_rdata     <= exp_instr(wr_addr);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      mem_k          = 1;

      repeat (2) @(negedge clk);
      #1;
      check("rst_addr",     imem_addr, 32'h0);
      check("rst_if_valid", {31'b0, if_valid}, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_if_pc",    if_pc, 32'h0);
      check("rst_misalign", {31'b0, misalign_err}, 32'h0);
      check("rst_wrap_addr", wr_addr, 32'hFFFF_FFFC);

      // C0: first cycle out of reset
      @(negedge clk); rst_n = 1'b1; #1;
      check("c0_req",  {31'b0, imem_req_valid}, 32'h1);
      check("c0_addr", imem_addr, 32'h0);
      // C1: waiting, response present
      @(negedge clk); #1;
      check("c1_req",   {31'b0, imem_req_valid}, 32'h0);
      check("c1_ifv",   {31'b0, if_valid}, 32'h0);
      // C2: slot holds 0x0, next request at 0x4
      @(negedge clk); #1;
      check("c2_ifv",   {31'b0, if_valid}, 32'h1);
      check("c2_ifpc",  if_pc, 32'h0);
      check("c2_instr", if_instr, exp_instr(32'h0));
      check("c2_req",   {31'b0, imem_req_valid}, 32'h1);
      check("c2_addr",  imem_addr, 32'h4);
      check("wrap_addr",  wr_addr, 32'h0);
      check("wrap_if_pc", wr_if_pc, 32'hFFFF_FFFC);
      check("wrap_instr", wr_if_instr, exp_instr(32'hFFFF_FFFC));
      // C3
      @(negedge clk); #1;
      check("c3_ifv", {31'b0, if_valid}, 32'h0);
      check("c3_req", {31'b0, imem_req_valid}, 32'h0);
      // C4
      @(negedge clk); #1;
      check("c4_ifpc",  if_pc, 32'h4);
      check("c4_instr", if_instr, exp_instr(32'h4));
      check("c4_addr",  imem_addr, 32'h8);
      check("c4_req",   {31'b0, imem_req_valid}, 32'h1);
      // C5
      @(negedge clk); #1;
      check("c5_ifv", {31'b0, if_valid}, 32'h0);
      // C6..C10: backpressure with slot full
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); if_ready = 1'b0; #1;
         check("bp_req",   {31'b0, imem_req_valid}, 32'h0);
         check("bp_ifv",   {31'b0, if_valid}, 32'h1);
         check("bp_ifpc",  if_pc, 32'h8);
         check("bp_instr", if_instr, exp_instr(32'h8));
      end
      // C11: release, drain and request in the same cycle
      @(negedge clk); if_ready = 1'b1; #1;
      check("rel_ifv",  {31'b0, if_valid}, 32'h1);
      check("rel_ifpc", if_pc, 32'h8);
      check("rel_req",  {31'b0, imem_req_valid}, 32'h1);
      check("rel_addr", imem_addr, 32'hC);
      // C12
      @(negedge clk); #1;
      check("c12_ifv", {31'b0, if_valid}, 32'h0);
      // C13: switch memory to k = 3 for the next request
      @(negedge clk); mem_k = 3; #1;
      check("c13_ifpc", if_pc, 32'hC);
      check("c13_addr", imem_addr, 32'h10);
      check("c13_req",  {31'b0, imem_req_valid}, 32'h1);
      // C14: redirect while waiting, no response yet
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      check("rw_req", {31'b0, imem_req_valid}, 32'h0);
      check("rw_ifv", {31'b0, if_valid}, 32'h0);
      // C15
      @(negedge clk); redirect_valid = 1'b0; #1;
      check("rw_c15_req", {31'b0, imem_req_valid}, 32'h0);
      // C16: stale response arrives
      @(negedge clk); #1;
      check("rw_stale_req", {31'b0, imem_req_valid}, 32'h0);
      check("rw_stale_ifv", {31'b0, if_valid}, 32'h0);
      // C17: new target issued, stale data not in slot
      @(negedge clk); mem_k = 1; #1;
      check("rw_addr",    imem_addr, 32'h100);
      check("rw_req2",    {31'b0, imem_req_valid}, 32'h1);
      check("rw_dropped", {31'b0, if_valid}, 32'h0);
      // C18
      @(negedge clk); #1;
      check("c18_ifv", {31'b0, if_valid}, 32'h0);
      // C19: first instruction on the redirected path
      @(negedge clk); #1;
      check("rw_ifpc",  if_pc, 32'h100);
      check("rw_instr", if_instr, exp_instr(32'h100));
      check("c19_addr", imem_addr, 32'h104);
      // C20: redirect coinciding with a response
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      check("rr_ifv", {31'b0, if_valid}, 32'h0);
      check("rr_req", {31'b0, imem_req_valid}, 32'h0);
      // C21
      @(negedge clk); redirect_valid = 1'b0; #1;
      check("rr_addr",    imem_addr, 32'h200);
      check("rr_req2",    {31'b0, imem_req_valid}, 32'h1);
      check("rr_dropped", {31'b0, if_valid}, 32'h0);
      // C22
      @(negedge clk); #1;
      check("c22_ifv", {31'b0, if_valid}, 32'h0);
      // C23: hold slot full
      @(negedge clk); if_ready = 1'b0; #1;
      check("c23_ifv",  {31'b0, if_valid}, 32'h1);
      check("c23_ifpc", if_pc, 32'h200);
      check("c23_req",  {31'b0, imem_req_valid}, 32'h0);
      // C24: misaligned redirect with slot full
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
      check("ma_ifv_mask", {31'b0, if_valid}, 32'h0);
      check("ma_pre",      {31'b0, misalign_err}, 32'h0);
      // C25
      @(negedge clk); redirect_valid = 1'b0; if_ready = 1'b1; #1;
      check("ma_pulse", {31'b0, misalign_err}, 32'h1);
      check("ma_addr",  imem_addr, 32'h100);
      check("ma_req",   {31'b0, imem_req_valid}, 32'h1);
      check("ma_flush", {31'b0, if_valid}, 32'h0);
      // C26
      @(negedge clk); #1;
      check("ma_end", {31'b0, misalign_err}, 32'h0);
      // C27: redirect while a request is accepted, slot full
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
      check("rf_ifv",  {31'b0, if_valid}, 32'h0);
      check("rf_req",  {31'b0, imem_req_valid}, 32'h1);
      check("rf_addr", imem_addr, 32'h104);
      // C28: response for old path dropped
      @(negedge clk); redirect_valid = 1'b0; #1;
      check("rf_wait_req", {31'b0, imem_req_valid}, 32'h0);
      check("rf_wait_ifv", {31'b0, if_valid}, 32'h0);
      // C29
      @(negedge clk); #1;
      check("rf_addr2", imem_addr, 32'h300);
      check("rf_ifv2",  {31'b0, if_valid}, 32'h0);
      // C30: reset asserted while a request is outstanding
      @(negedge clk); rst_n = 1'b0; #1;
      check("mr_addr", imem_addr, 32'h0);
      check("mr_ifv",  {31'b0, if_valid}, 32'h0);
      // C31
      @(negedge clk); rst_n = 1'b1; #1;
      check("mr_req",  {31'b0, imem_req_valid}, 32'h1);
      check("mr_addr2", imem_addr, 32'h0);
      @(negedge clk); #1;
      check("mr_wait", {31'b0, imem_req_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
